// File: rtl/uart_fifo_wb_if.sv
// rtl/uart_fifo_wb_if.sv - Wishbone peripheral bus bundle for uart_fifo_wb
//   master: drives cyc/stb/we/adr/dat_i/sel, receives ack/dat_o/stall/err
//   slave : the UART side of the same signals
interface uart_fifo_wb_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        wb_stall_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_ack_o, wb_dat_o, wb_stall_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_ack_o, wb_dat_o, wb_stall_o, wb_err_o
    );
endinterface

// File: rtl/uart_fifo_wb.sv
// rtl/uart_fifo_wb.sv - Wishbone UART with TX/RX FIFOs, runtime divisor, parity, error flags, irq
//   clk, rst (async, active-low)
//   wb    : Wishbone slave (registered ack, one ack per two cycles on a held strobe)
//   rx_i  : serial in, idle high;  tx_o : serial out, idle high;  irq_o : level interrupt
//   Registers (adr[3:2]): 0 DATA, 1 STATUS, 2 CTRL, 3 DIV
module uart_fifo_wb #(
    parameter int CLK_DIV_RESET = 4167,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_fifo_wb_if.slave wb,
    input  logic          rx_i,
    output logic          tx_o,
    output logic          irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [4:0]  ctrl;
    logic [15:0] div;
    logic        ovr, perr, ferr;

    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wr, tx_rd, rx_wr, rx_rd;

    // ---------------- bus decode ----------------
    logic        req, wr_req, rd_req;
    logic [1:0]  adr;
    logic [31:0] rdata;
    logic        unused_bits;

    assign req    = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign wr_req = req & wb.wb_we_i;
    assign rd_req = req & ~wb.wb_we_i;
    assign adr    = wb.wb_adr_i[3:2];
    assign wb.wb_stall_o = 1'b0;
    assign wb.wb_err_o   = 1'b0;
    assign unused_bits = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:16], wb.wb_sel_i[3:1]};

    // ---------------- FIFO status ----------------
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, rx_push, rx_pop, rx_push_ok, ovr_set;
    logic [7:0] tx_head, rx_head, rx_pdata;

    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
    assign tx_head  = tx_mem[tx_rd[AW-1:0]];
    assign rx_head  = rx_mem[rx_rd[AW-1:0]];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign tx_push    = wr_req && (adr == 2'd0) && wb.wb_sel_i[0] && (!tx_full || tx_pop);
    assign rx_pop     = rd_req && (adr == 2'd0) && !rx_empty;
    assign rx_push_ok = rx_push && (!rx_full || rx_pop);
    assign ovr_set    = rx_push && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (tx_push)    tx_mem[tx_wr[AW-1:0]] <= wb.wb_dat_i[7:0];
        if (rx_push_ok) rx_mem[rx_wr[AW-1:0]] <= rx_pdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wr <= '0;
            tx_rd <= '0;
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (tx_push)    tx_wr <= tx_wr + PTR_ONE;
            if (tx_pop)     tx_rd <= tx_rd + PTR_ONE;
            if (rx_push_ok) rx_wr <= rx_wr + PTR_ONE;
            if (rx_pop)     rx_rd <= rx_rd + PTR_ONE;
        end
    end

    // ---------------- register file ----------------
    logic tx_busy;
    logic cfg_pen, cfg_odd;
    assign cfg_pen = (ctrl[1:0] == 2'b01) || (ctrl[1:0] == 2'b10);
    assign cfg_odd = (ctrl[1:0] == 2'b10);

    always_comb begin
        rdata = '0;
        case (adr)
            2'd0: rdata = {24'b0, rx_empty ? 8'h00 : rx_head};
            2'd1: rdata = {24'b0, ferr, perr, ovr, tx_busy, tx_full, tx_empty, rx_full, !rx_empty};
            2'd2: rdata = {27'b0, ctrl};
            default: rdata = {16'b0, div};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
            ctrl        <= '0;
            div         <= 16'(CLK_DIV_RESET);
        end else begin
            wb.wb_ack_o <= req;
            wb.wb_dat_o <= rd_req ? rdata : 32'h0;
            if (wr_req && adr == 2'd2) ctrl <= wb.wb_dat_i[4:0];
            if (wr_req && adr == 2'd3)
                div <= (wb.wb_dat_i[15:0] < 16'd4) ? 16'd4 : wb.wb_dat_i[15:0];
        end
    end

    // ---------------- sticky flags and interrupt ----------------
    logic clr, perr_set, ferr_set;
    assign clr = wr_req && (adr == 2'd1) && wb.wb_sel_i[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr   <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            // A new event in the same cycle as a clear keeps the flag set.
            ovr   <= ovr_set  | (ovr  & ~(clr & wb.wb_dat_i[5]));
            perr  <= perr_set | (perr & ~(clr & wb.wb_dat_i[6]));
            ferr  <= ferr_set | (ferr & ~(clr & wb.wb_dat_i[7]));
            irq_o <= (ctrl[2] & ~rx_empty) | (ctrl[3] & tx_empty & ~tx_busy) |
                     (ctrl[4] & (ovr | perr | ferr));
        end
    end

    // ---------------- transmitter ----------------
    state_t      tx_state;
    logic [15:0] tx_cnt, tx_div;
    logic [7:0]  tx_sh;
    logic [2:0]  tx_bit;
    logic        tx_pen, tx_pbit, tx_end;

    assign tx_busy = (tx_state != S_IDLE);
    assign tx_end  = (tx_cnt == tx_div - 16'd1);
    // Popping at the end of STOP starts the next frame with no idle gap.
    assign tx_pop  = !tx_empty && ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_end));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= S_IDLE;
            tx_o     <= 1'b1;
            tx_cnt   <= '0;
            tx_div   <= 16'd4;
            tx_sh    <= '0;
            tx_bit   <= '0;
            tx_pen   <= 1'b0;
            tx_pbit  <= 1'b0;
        end else if (tx_pop) begin
            tx_state <= S_START;
            tx_o     <= 1'b0;
            tx_cnt   <= '0;
            tx_div   <= div;
            tx_sh    <= tx_head;
            tx_pen   <= cfg_pen;
            tx_pbit  <= (^tx_head) ^ cfg_odd;
        end else if (tx_state != S_IDLE) begin
            if (!tx_end) begin
                tx_cnt <= tx_cnt + 16'd1;
            end else begin
                tx_cnt <= '0;
                case (tx_state)
                    S_START: begin
                        tx_state <= S_DATA;
                        tx_o     <= tx_sh[0];
                        tx_bit   <= '0;
                    end
                    S_DATA: begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= tx_pen ? S_PARITY : S_STOP;
                            tx_o     <= tx_pen ? tx_pbit : 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx_sh  <= tx_sh >> 1;
                            tx_o   <= tx_sh[1];
                        end
                    end
                    S_PARITY: begin
                        tx_state <= S_STOP;
                        tx_o     <= 1'b1;
                    end
                    default: tx_state <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------- receiver ----------------
    state_t      rx_state;
    logic [1:0]  rx_sync;
    logic [15:0] rx_cnt, rx_div, rx_half;
    logic [7:0]  rx_sh;
    logic [2:0]  rx_bit;
    logic        rx_s, rx_pen, rx_odd, rx_pbit, rx_end;

    assign rx_s    = rx_sync[1];
    assign rx_half = (rx_div - 16'd1) >> 1;
    assign rx_end  = (rx_cnt == rx_div - 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync  <= 2'b11;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= 16'd4;
            rx_sh    <= '0;
            rx_bit   <= '0;
            rx_pen   <= 1'b0;
            rx_odd   <= 1'b0;
            rx_pbit  <= 1'b0;
            rx_push  <= 1'b0;
            rx_pdata <= '0;
            perr_set <= 1'b0;
            ferr_set <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx_i};
            rx_push  <= 1'b0;
            perr_set <= 1'b0;
            ferr_set <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= S_START;
                        rx_cnt   <= '0;
                        rx_div   <= div;
                        rx_pen   <= cfg_pen;
                        rx_odd   <= cfg_odd;
                    end
                end
                S_START: begin
                    // Mid-start sample; a line already high again was a glitch.
                    if (rx_cnt == rx_half) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_end) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        if (rx_bit == 3'd7) rx_state <= rx_pen ? S_PARITY : S_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (rx_end) begin
                        rx_cnt   <= '0;
                        rx_pbit  <= rx_s;
                        rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_end) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                        if (!rx_s) begin
                            ferr_set <= 1'b1;
                        end else begin
                            rx_push  <= 1'b1;
                            rx_pdata <= rx_sh;
                            perr_set <= rx_pen && (rx_pbit != ((^rx_sh) ^ rx_odd));
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_wb.sv
// tb/tb_uart_fifo_wb.sv - self-checking bench for uart_fifo_wb
module tb_uart_fifo_wb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_fifo_wb_if bus();
    logic rx_i, tx_o, irq_o;
    logic loop_en = 1'b0;
    logic rx_drv  = 1'b1;
    assign rx_i = loop_en ? tx_o : rx_drv;

    uart_fifo_wb #(.CLK_DIV_RESET(4167), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .wb(bus), .rx_i(rx_i), .tx_o(tx_o), .irq_o(irq_o)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int unsigned cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // reference model state
    int         m_div = 4167;
    int         m_par = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         tx_starts[$];
    logic       m_ovr = 0, m_perr = 0, m_ferr = 0;

    function automatic bit par_en(input int p);
        return (p == 1) || (p == 2);
    endfunction

    function automatic logic [31:0] exp_status();
        return {24'b0, m_ferr, m_perr, m_ovr, 1'b0, 1'b0, 1'b1,
                rx_exp.size() == 16, rx_exp.size() != 0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] q);
        int k;
        @(negedge clk);
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we;
        bus.wb_adr_i = {28'b0, a, 2'b00}; bus.wb_dat_i = d; bus.wb_sel_i = sel;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.wb_ack_o) break;
        end
        if (k == 20) begin
            n_chk++; n_fail++;
            $display("FAIL wb_ack_timeout: no ack within 20 cycles adr=%0d", a);
        end
        q = bus.wb_dat_o;
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, 4'hF, q);
    endtask

    task automatic wb_rd(input logic [1:0] a, output logic [31:0] q);
        wb_xfer(1'b0, a, 32'h0, 4'hF, q);
    endtask

    task automatic set_cfg(input int dv, input int par, input logic [4:0] irqs);
        wb_wr(2'd3, dv);
        wb_wr(2'd2, {27'b0, irqs[4:2], 2'(par)});
        m_div = dv;
        m_par = par;
    endtask

    // Serial frame decoder on tx_o; compares against the expected-byte queue.
    initial begin
        logic [7:0] b;
        int d;
        bit pen, odd;
        forever begin
            @(negedge clk);
            if (rst && tx_o === 1'b0) begin
                tx_starts.push_back(cyc_n);
                d = m_div; pen = par_en(m_par); odd = (m_par == 2);
                repeat (d / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = tx_o;
                end
                if (pen) begin
                    repeat (d) @(negedge clk);
                    check("tx_parity_bit", {31'b0, tx_o}, {31'b0, (^b) ^ odd});
                end
                repeat (d) @(negedge clk);
                check("tx_stop_bit", {31'b0, tx_o}, 32'h1);
                if (tx_exp.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL tx_unexpected_frame: got 0x%02h expected none", b);
                end else begin
                    check("tx_byte", {24'b0, b}, {24'b0, tx_exp.pop_front()});
                end
            end
        end
    end

    // Bench-driven serial frame into rx_i, with model update.
    task automatic send_frame(input logic [7:0] v, input bit bad_par, input bit stop_bit);
        bit pen;
        pen = par_en(m_par);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (m_div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = v[i];
            repeat (m_div) @(negedge clk);
        end
        if (pen) begin
            rx_drv = (^v) ^ (m_par == 2) ^ bad_par;
            repeat (m_div) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (m_div) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * m_div) @(negedge clk);
        if (!stop_bit) begin
            m_ferr = 1;
        end else begin
            if (pen && bad_par) m_perr = 1;
            if (rx_exp.size() == 16) m_ovr = 1;
            else rx_exp.push_back(v);
        end
    endtask

    task automatic wait_tx_idle();
        logic [31:0] s;
        int k;
        for (k = 0; k < 3000; k++) begin
            wb_rd(2'd1, s);
            if (s[2] && !s[4]) break;
        end
        if (k == 3000) begin
            n_chk++; n_fail++;
            $display("FAIL tx_idle_timeout: status 0x%08h", s);
        end
        repeat (2 * m_div + 10) @(negedge clk);
    endtask

    task automatic drain_rx();
        logic [31:0] q;
        while (rx_exp.size() != 0) begin
            wb_rd(2'd0, q);
            check("rx_data", q, {24'b0, rx_exp.pop_front()});
        end
        wb_rd(2'd0, q);
        check("rx_data_empty", q, 32'h0);
        wb_rd(2'd1, q);
        check("status_after_drain", q, exp_status());
    endtask

    typedef struct {
        bit          do_wr;
        logic [1:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [1:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic void add_vec(input bit w, input logic [1:0] wa, input logic [31:0] wd,
                                    input logic [3:0] ws, input logic [1:0] ra,
                                    input logic [31:0] exp);
        vec_t v;
        v.do_wr = w; v.wa = wa; v.wd = wd; v.ws = ws; v.ra = ra; v.exp = exp;
        vt.push_back(v);
    endfunction

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        logic [31:0] q;
        logic [10:0] fr;
        int n0, nb;
        logic [7:0] v;

        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_sel_i = 0;

        add_vec(1, 2'd2, 32'h0000_001F, 4'hF, 2'd2, 32'h0000_001F);
        add_vec(1, 2'd2, 32'hFFFF_FFE0, 4'hF, 2'd2, 32'h0000_0000);
        add_vec(1, 2'd3, 32'h0000_0000, 4'hF, 2'd3, 32'h0000_0004);
        add_vec(1, 2'd3, 32'h0000_0003, 4'hF, 2'd3, 32'h0000_0004);
        add_vec(1, 2'd3, 32'h0000_0004, 4'hF, 2'd3, 32'h0000_0004);
        add_vec(1, 2'd3, 32'hABCD_1234, 4'hF, 2'd3, 32'h0000_1234);
        add_vec(1, 2'd3, 32'h0000_FFFF, 4'hF, 2'd3, 32'h0000_FFFF);
        add_vec(1, 2'd0, 32'h0000_005A, 4'hE, 2'd1, 32'h0000_0004);
        add_vec(1, 2'd1, 32'h0000_00FF, 4'hF, 2'd1, 32'h0000_0004);
        add_vec(0, 2'd0, 32'h0,         4'hF, 2'd0, 32'h0000_0000);
        add_vec(1, 2'd2, 32'h0000_000A, 4'hF, 2'd2, 32'h0000_000A);

        // reset
        repeat (4) @(negedge clk);
        check("reset_tx_o", {31'b0, tx_o}, 32'h1);
        check("reset_irq", {31'b0, irq_o}, 32'h0);
        check("reset_ack", {31'b0, bus.wb_ack_o}, 32'h0);
        check("reset_dat", bus.wb_dat_o, 32'h0);
        rst = 1'b1;
        wb_rd(2'd3, q);
        check("reset_div", q, 32'd4167);
        wb_rd(2'd1, q);
        check("reset_status", q, 32'h04);

        // held strobe: ack every second cycle
        @(negedge clk);
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 0; bus.wb_adr_i = 32'hC;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("held_stb_ack", {31'b0, bus.wb_ack_o}, {31'b0, (i % 2) == 0});
        end
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0;

        // table-driven register vectors
        foreach (vt[i]) begin
            if (vt[i].do_wr) wb_xfer(1'b1, vt[i].wa, vt[i].wd, vt[i].ws, q);
            wb_rd(vt[i].ra, q);
            check($sformatf("vec%0d", i), q, vt[i].exp);
        end

        // interrupt sources on an idle UART
        set_cfg(4, 0, 5'b01000);
        repeat (3) @(negedge clk);
        check("irq_tx_idle", {31'b0, irq_o}, 32'h1);
        set_cfg(4, 0, 5'b00100);
        repeat (3) @(negedge clk);
        check("irq_rx_empty", {31'b0, irq_o}, 32'h0);

        // exact TX waveform for 0xA5, DIV=4, no parity
        set_cfg(4, 0, 5'b0);
        tx_exp.push_back(8'hA5);
        wb_wr(2'd0, 32'hA5);
        for (n0 = 0; n0 < 20; n0++) begin
            if (tx_o === 1'b0) break;
            @(negedge clk);
        end
        if (n0 == 20) begin
            n_chk++; n_fail++;
            $display("FAIL a5_start_timeout: tx_o never went low");
        end
        fr = {1'b1, 1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 44; i++) begin
            check($sformatf("a5_wave_c%0d", i), {31'b0, tx_o}, {31'b0, fr[i / 4]});
            @(negedge clk);
        end
        wait_tx_idle();
        check("a5_tx_sent", tx_exp.size(), 0);

        // loopback, even parity, back-to-back frames
        loop_en = 1'b1;
        set_cfg(4, 1, 5'b0);
        n0 = tx_starts.size();
        tx_exp.push_back(8'h3C); tx_exp.push_back(8'h7E);
        rx_exp.push_back(8'h3C); rx_exp.push_back(8'h7E);
        wb_wr(2'd0, 32'h3C);
        wb_wr(2'd0, 32'h7E);
        wait_tx_idle();
        check("loop_frames", tx_starts.size() - n0, 2);
        if (tx_starts.size() - n0 == 2)
            check("back_to_back_gap", tx_starts[n0 + 1] - tx_starts[n0], 44);
        drain_rx();

        // randomized loopback rounds
        for (int r = 0; r < 4; r++) begin
            set_cfg($urandom_range(4, 9), $urandom_range(0, 3), 5'b0);
            nb = $urandom_range(1, 8);
            for (int i = 0; i < nb; i++) begin
                v = 8'($urandom);
                tx_exp.push_back(v);
                rx_exp.push_back(v);
                wb_wr(2'd0, {24'b0, v});
            end
            wait_tx_idle();
            check("rand_tx_all_sent", tx_exp.size(), 0);
            drain_rx();
        end
        loop_en = 1'b0;

        // TX FIFO overflow with the first frame in flight
        set_cfg(16, 0, 5'b0);
        for (int i = 0; i < 18; i++) begin
            if (i < 17) tx_exp.push_back(8'(8'h40 + i));
            wb_wr(2'd0, 32'(8'h40 + i));
        end
        wb_rd(2'd1, q);
        check("tx_full_status", q, 32'h18);
        wait_tx_idle();
        check("tx_overflow_count", tx_exp.size(), 0);

        // RX overrun
        set_cfg(4, 0, 5'b0);
        for (int i = 0; i < 17; i++) send_frame(8'($urandom), 1'b0, 1'b1);
        wb_rd(2'd1, q);
        check("overrun_status", q, exp_status());
        wb_wr(2'd1, 32'h20);
        m_ovr = 0;
        wb_rd(2'd1, q);
        check("overrun_cleared", q, exp_status());
        drain_rx();

        // framing error, error interrupt
        send_frame(8'h55, 1'b0, 1'b0);
        wb_rd(2'd1, q);
        check("frame_err_status", q, exp_status());
        set_cfg(4, 0, 5'b10000);
        repeat (3) @(negedge clk);
        check("irq_err", {31'b0, irq_o}, 32'h1);
        wb_wr(2'd1, 32'h80);
        m_ferr = 0;
        repeat (3) @(negedge clk);
        check("irq_err_cleared", {31'b0, irq_o}, 32'h0);

        // random parity frames with random parity corruption
        for (int i = 0; i < 6; i++) begin
            set_cfg($urandom_range(4, 7), $urandom_range(1, 2), 5'b0);
            send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            wb_rd(2'd1, q);
            check("parity_status", q, exp_status());
        end
        wb_wr(2'd1, 32'hE0);
        m_perr = 0; m_ovr = 0; m_ferr = 0;
        drain_rx();

        // one-clock low glitch on rx
        set_cfg(8, 0, 5'b0);
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        wb_rd(2'd1, q);
        check("glitch_status", q, 32'h04);
        wb_rd(2'd0, q);
        check("glitch_no_data", q, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_fifo_wb.md
Name: uart_fifo_wb

Overview:
Wishbone-attached UART, successor to the single-byte UART peripheral. It adds parametrised TX/RX FIFOs, a runtime baud divisor, optional even/odd parity, sticky error flags and a single maskable interrupt. It sits on the peripheral Wishbone bus next to the core and replaces direct rx_byte/tx strobes with a 4-word register map.

Parameters:
CLK_DIV_RESET, 4167, reset value of DIV register (clk cycles per bit; 40 MHz / 9600).
FIFO_DEPTH, 16, entries per FIFO; power of 2, minimum 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_adr_i  in  32  byte address; only [3:2] decoded
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects
wb_ack_o  out  1  registered acknowledge
wb_dat_o  out  32  read data, valid with ack
wb_stall_o  out  1  constant 0
wb_err_o  out  1  constant 0
rx_i  in  1  serial input, idle high
tx_o  out  1  serial output, idle high
irq_o  out  1  level interrupt

Behaviour:
- Reset (rst=0, async): tx_o=1, wb_ack_o=0, wb_dat_o=0, irq_o=0, both FIFOs empty, CTRL=0, DIV=CLK_DIV_RESET, sticky flags 0, TX/RX FSMs IDLE, rx synchroniser=11. Reset mid-frame aborts the frame; tx_o is 1 immediately.
- Bus: a request is cyc&stb&~ack at edge N. The write or pop takes effect at edge N. ack=1 and read data are driven for the cycle after N. Ack then drops for one cycle, so a held stb gets ack every second cycle.
- Register map, adr[3:2]:
  - 0 DATA:
    - Write with sel[0] pushes dat[7:0] into the TX FIFO. A write while full is dropped.
    - Read returns {24'b0, rx_head} and pops the RX FIFO. Reading while empty returns 0 and leaves the pointers unchanged.
  - 1 STATUS:
    - Read bits: [0] rx_nempty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] tx_busy, [5] overrun, [6] parity_err, [7] frame_err, others 0.
    - Writing 1 to bits [7:5] (with sel[0]) clears those bits; all other bits are read-only.
  - 2 CTRL: [1:0] parity (00 none, 01 even, 10 odd, 11 treated as none), [2] rx_irq_en, [3] tx_irq_en, [4] err_irq_en. Read back as written.
  - 3 DIV: [15:0] clocks per bit. A write of a value <4 stores 4. Reads return the stored value.
- irq_o (registered) = (rx_irq_en & rx_nempty) | (tx_irq_en & tx_empty & ~tx_busy) | (err_irq_en & (overrun | parity_err | frame_err)).
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: when the FIFO is non-empty, pop one byte, latch DIV and parity mode, go to START. tx_busy=1 from START through STOP.
  - START drives 0, DATA drives 8 bits LSB first, PARITY (only if enabled) drives the even/odd bit, STOP drives 1. Each state lasts DIV cycles.
  - The next frame starts the cycle after STOP ends (back-to-back, no gap). Changing DIV or CTRL mid-frame affects only the next frame.
- RX path: rx_i passes through a 2-flop synchroniser. FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: sync=0 latches DIV and parity, goes to START.
  - START: sample at count (DIV-1)/2. If 1, glitch: return to IDLE and push nothing. If 0, go to DATA.
  - DATA: sample 8 bits at DIV intervals, LSB first. PARITY (if enabled) is sampled DIV later, then STOP is sampled DIV later.
  - At STOP sample: stop=0 sets frame_err and discards the byte. Otherwise, a parity mismatch sets parity_err and the byte is still pushed.
  - Push into a full RX FIFO discards the new byte and sets overrun; FIFO contents are unchanged.
  - Return to IDLE in the cycle after the STOP sample (mid-stop-bit), allowing back-to-back reception.
- FIFOs: circular, pointer width clog2(FIFO_DEPTH)+1, wrap at FIFO_DEPTH. Simultaneous push and pop:
  - Not empty and not full: both occur, count unchanged.
  - Full: pop then push, both accepted.
  - Empty: only the push occurs.
- STATUS write-1-clear coinciding with a new flag event: the set wins.

Test Plan:
- Reset, then read DIV and STATUS -> DIV=4167, STATUS=0x04 (tx_empty), tx_o=1, irq_o=0.
- DIV=4, parity none, write 0xA5 -> tx_o: 0 for 4 clk, then bits 1,0,1,0,0,1,0,1 at 4 clk each, then 1 for 4 clk. tx_busy=1 for 40 clk total.
- DIV=4, even parity, loopback tx_o->rx_i, write 0x3C,0x7E -> frames back-to-back with parity bits 0 and 0. RX DATA reads return 0x3C then 0x7E, then 0x00 with rx_nempty=0.
- Write FIFO_DEPTH+2 bytes with TX blocked at frame 1 -> tx_full=1, 17 bytes transmitted in total (1 in flight + 16 queued), extras dropped.
- Receive FIFO_DEPTH+1 frames without reading -> overrun=1, FIFO holds the first 16. Write 0x20 to STATUS -> overrun=0.
- Drive a stop bit of 0 on 0x55 -> frame_err=1, RX FIFO empty. With err_irq_en=1, irq_o=1. A 1-clk low glitch on rx_i -> no push, no flags set.
